// File: rtl/lcd_pkg.sv
// Shared opcodes, panel defaults and scheduler state encoding for the LCD fill path.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int DEF_COL_OFFSET = 40;
    localparam int DEF_ROW_OFFSET = 53;
    localparam int DEF_WIDTH      = 240;
    localparam int DEF_HEIGHT     = 135;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET_C,
        S_CASET_D,
        S_RASET_C,
        S_RASET_D,
        S_RAMWR_C,
        S_PIXEL,
        S_FINISH
    } sched_state_t;

    // Window bytes go out as start[15:8], start[7:0], end[15:8], end[7:0].
    function automatic logic [7:0] addr_byte(input logic [1:0] idx,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
        logic [7:0] r;
        case (idx)
            2'd0:    r = a[15:8];
            2'd1:    r = a[7:0];
            2'd2:    r = b[15:8];
            default: r = b[7:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin: on a tie the requester not granted last wins.
module lcd_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic       o_gnt_id
);

    logic r_last;

    always_comb begin
        o_gnt_id = i_req[1];
        if (i_req == 2'b11)
            o_gnt_id = ~r_last;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_last <= 1'b1;
        else if (i_accept)
            r_last <= o_gnt_id;
    end

endmodule

// File: rtl/lcd_fill_scheduler.sv
// Arbitrates two fill requesters and emits CASET/RASET/RAMWR plus RGB565 pixel bytes
// onto a valid/ready byte stream toward the SPI serializer.
module lcd_fill_scheduler
    import lcd_pkg::*;
#(
    parameter int COL_OFFSET = DEF_COL_OFFSET,
    parameter int ROW_OFFSET = DEF_ROW_OFFSET,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_x0,
    input  logic [7:0]  req0_x1,
    input  logic [7:0]  req0_y0,
    input  logic [7:0]  req0_y1,
    input  logic [15:0] req0_color,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_x0,
    input  logic [7:0]  req1_x1,
    input  logic [7:0]  req1_y0,
    input  logic [7:0]  req1_y1,
    input  logic [15:0] req1_color,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_dc,
    output logic        out_last,
    output logic        busy,
    output logic        active_id,
    output logic        done,
    output logic        err
);

    sched_state_t r_state, w_next;
    logic [7:0]   r_x0, r_x1, r_y0, r_y1, r_col, r_row;
    logic [15:0]  r_color;
    logic [1:0]   r_idx;
    logic         r_active;

    logic         w_accept, w_gid, w_bad, w_xfer, w_pix_end;
    logic [7:0]   w_x0, w_x1, w_y0, w_y1;
    logic [15:0]  w_color, w_cs, w_ce, w_rs, w_re;

    // Ready is combinational in IDLE so the accept cycle is the ready cycle.
    assign w_accept = (r_state == S_IDLE) && init_done && !reset && (req0_valid || req1_valid);

    lcd_rr_arbiter u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    ({req1_valid, req0_valid}),
        .i_accept (w_accept),
        .o_gnt_id (w_gid)
    );

    assign w_x0    = w_gid ? req1_x0    : req0_x0;
    assign w_x1    = w_gid ? req1_x1    : req0_x1;
    assign w_y0    = w_gid ? req1_y0    : req0_y0;
    assign w_y1    = w_gid ? req1_y1    : req0_y1;
    assign w_color = w_gid ? req1_color : req0_color;

    assign w_bad = (w_x0 > w_x1) || (w_y0 > w_y1) ||
                   ({8'd0, w_x1} >= 16'(WIDTH)) || ({8'd0, w_y1} >= 16'(HEIGHT));

    assign req0_ready = w_accept & ~w_gid;
    assign req1_ready = w_accept &  w_gid;
    assign err        = w_accept &  w_bad;

    assign w_cs = {8'd0, r_x0} + 16'(COL_OFFSET);
    assign w_ce = {8'd0, r_x1} + 16'(COL_OFFSET);
    assign w_rs = {8'd0, r_y0} + 16'(ROW_OFFSET);
    assign w_re = {8'd0, r_y1} + 16'(ROW_OFFSET);

    assign w_xfer    = out_valid & out_ready;
    assign w_pix_end = r_idx[0] && (r_col == r_x1) && (r_row == r_y1);

    assign busy      = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done      = (r_state == S_FINISH);
    assign active_id = r_active;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept && !w_bad)         w_next = S_CASET_C;
            S_CASET_C: if (w_xfer)                     w_next = S_CASET_D;
            S_CASET_D: if (w_xfer && r_idx == 2'd3)    w_next = S_RASET_C;
            S_RASET_C: if (w_xfer)                     w_next = S_RASET_D;
            S_RASET_D: if (w_xfer && r_idx == 2'd3)    w_next = S_RAMWR_C;
            S_RAMWR_C: if (w_xfer)                     w_next = S_PIXEL;
            S_PIXEL:   if (w_xfer && w_pix_end)        w_next = S_FINISH;
            S_FINISH:                                  w_next = S_IDLE;
            default:                                   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_dc    = 1'b1;
        out_last  = 1'b0;
        case (r_state)
            S_CASET_C: begin out_valid = 1'b1; out_dc = 1'b0; out_data = CMD_CASET; end
            S_CASET_D: begin out_valid = 1'b1; out_data = addr_byte(r_idx, w_cs, w_ce); end
            S_RASET_C: begin out_valid = 1'b1; out_dc = 1'b0; out_data = CMD_RASET; end
            S_RASET_D: begin out_valid = 1'b1; out_data = addr_byte(r_idx, w_rs, w_re); end
            S_RAMWR_C: begin out_valid = 1'b1; out_dc = 1'b0; out_data = CMD_RAMWR; end
            S_PIXEL: begin
                out_valid = 1'b1;
                out_data  = r_idx[0] ? r_color[7:0] : r_color[15:8];
                out_last  = w_pix_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_active <= 1'b0;
            r_col    <= 8'd0;
            r_row    <= 8'd0;
            r_x0     <= 8'd0;
            r_x1     <= 8'd0;
            r_y0     <= 8'd0;
            r_y1     <= 8'd0;
            r_color  <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_bad) begin
                r_x0     <= w_x0;
                r_x1     <= w_x1;
                r_y0     <= w_y0;
                r_y1     <= w_y1;
                r_color  <= w_color;
                r_active <= w_gid;
                r_idx    <= 2'd0;
            end
            if (w_xfer) begin
                case (r_state)
                    S_CASET_D, S_RASET_D: r_idx <= r_idx + 2'd1;
                    S_RAMWR_C: begin
                        r_col <= r_x0;
                        r_row <= r_y0;
                        r_idx <= 2'd0;
                    end
                    S_PIXEL: begin
                        // Bit 0 selects high/low colour byte; position steps after the low byte.
                        r_idx <= {1'b0, ~r_idx[0]};
                        if (r_idx[0]) begin
                            if (r_col == r_x1) begin
                                r_col <= r_x0;
                                r_row <= r_row + 8'd1;
                            end else begin
                                r_col <= r_col + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_fill_scheduler.sv
// Directed bench for lcd_fill_scheduler: table of fill jobs plus arbitration, gating and reset sequences.
module tb_lcd_fill_scheduler;

    logic        clk = 1'b0;
    logic        reset, init_done, out_ready;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_x0, req0_x1, req0_y0, req0_y1;
    logic [7:0]  req1_x0, req1_x1, req1_y0, req1_y1;
    logic [15:0] req0_color, req1_color;
    logic        out_valid, out_dc, out_last, busy, active_id, done, err;
    logic [7:0]  out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcd_fill_scheduler dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x0(req0_x0), .req0_x1(req0_x1), .req0_y0(req0_y0), .req0_y1(req0_y1),
        .req0_color(req0_color),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x0(req1_x0), .req1_x1(req1_x1), .req1_y0(req1_y0), .req1_y1(req1_y1),
        .req1_color(req1_color),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dc(out_dc), .out_last(out_last), .busy(busy), .active_id(active_id),
        .done(done), .err(err)
    );

    typedef struct {
        logic        rid;
        logic [7:0]  x0, x1, y0, y1;
        logic [15:0] color;
        logic        bp;
        logic        exp_err;
        logic [87:0] exp_hdr;
        int          exp_len;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic rid, input logic [7:0] x0, input logic [7:0] x1,
                           input logic [7:0] y0, input logic [7:0] y1, input logic [15:0] c);
        if (rid) begin
            req1_x0 = x0; req1_x1 = x1; req1_y0 = y0; req1_y1 = y1; req1_color = c;
        end else begin
            req0_x0 = x0; req0_x1 = x1; req0_y0 = y0; req0_y1 = y1; req0_color = c;
        end
    endtask

    task automatic wait_done(input string tag);
        int c;
        for (c = 0; c < 500; c++) begin
            @(negedge clk); #1;
            if (done) break;
        end
        check(tag, 32'(c < 500), 32'd1);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        logic [7:0] q[$];
        logic       seen, pend, got_done, done_ok, prev_stall, p_dc, p_last;
        logic [7:0] p_data, eb;
        int         nv, unstable, nlast, last_idx, hbad, pbad;
        seen = 0; pend = 0; got_done = 0; done_ok = 0; prev_stall = 0;
        p_dc = 0; p_last = 0; p_data = 0;
        nv = 0; unstable = 0; nlast = 0; last_idx = -1; hbad = 0; pbad = 0;

        @(negedge clk);
        out_ready = 1'b1;
        set_req(v.rid, v.x0, v.x1, v.y0, v.y1, v.color);
        if (v.rid) req1_valid = 1'b1; else req0_valid = 1'b1;
        #1;
        for (int c = 0; c < 200; c++) begin
            if (v.rid ? req1_ready : req0_ready) begin seen = 1; break; end
            @(negedge clk); #1;
        end
        check($sformatf("%s_ready", tag), 32'(seen), 32'd1);
        check($sformatf("%s_err", tag), 32'(err), 32'(v.exp_err));
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        if (!seen) return;
        if (v.exp_err) begin
            for (int c = 0; c < 5; c++) begin
                if (out_valid || busy) nv++;
                @(negedge clk); #1;
            end
            check($sformatf("%s_noout", tag), 32'(nv), 32'd0);
            return;
        end
        check($sformatf("%s_first", tag), {22'd0, out_valid, out_dc, out_data}, {22'd0, 1'b1, 1'b0, 8'h2A});
        check($sformatf("%s_id", tag), 32'(active_id), 32'(v.rid));
        for (int c = 0; c < 4 * v.exp_len + 100; c++) begin
            if (done) begin got_done = 1; done_ok = pend; break; end
            if (prev_stall && (!out_valid || out_data !== p_data || out_dc !== p_dc || out_last !== p_last))
                unstable++;
            pend = 0;
            if (out_valid && out_ready) begin
                q.push_back(out_data);
                if (out_last) begin nlast++; last_idx = q.size() - 1; pend = 1; end
            end
            prev_stall = out_valid && !out_ready;
            p_data = out_data; p_dc = out_dc; p_last = out_last;
            @(negedge clk);
            out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            eb = v.exp_hdr[87 - 8*i -: 8];
            if (i >= q.size() || q[i] !== eb) hbad++;
        end
        for (int i = 11; i < q.size(); i++) begin
            eb = ((i - 11) % 2 == 0) ? v.color[15:8] : v.color[7:0];
            if (q[i] !== eb) pbad++;
        end
        check($sformatf("%s_done", tag), 32'(got_done), 32'd1);
        check($sformatf("%s_donetime", tag), 32'(done_ok), 32'd1);
        check($sformatf("%s_len", tag), 32'(q.size()), 32'(v.exp_len));
        check($sformatf("%s_hdr", tag), 32'(hbad), 32'd0);
        check($sformatf("%s_pix", tag), 32'(pbad), 32'd0);
        check($sformatf("%s_lastpos", tag), 32'(last_idx), 32'(v.exp_len - 1));
        check($sformatf("%s_nlast", tag), 32'(nlast), 32'd1);
        check($sformatf("%s_stable", tag), 32'(unstable), 32'd0);
    endtask

    initial begin
        int cnt, nr;
        vecs[0] = '{1'b0, 8'd0,   8'd1,   8'd0,   8'd0,   16'hF800, 1'b0, 1'b0, 88'h2A00280029_2B00350035_2C, 15};
        vecs[1] = '{1'b1, 8'd200, 8'd239, 8'd100, 8'd134, 16'h1234, 1'b1, 1'b0, 88'h2A00F00117_2B009900BB_2C, 2811};
        vecs[2] = '{1'b0, 8'd5,   8'd5,   8'd7,   8'd9,   16'hABCD, 1'b0, 1'b0, 88'h2A002D002D_2B003C003E_2C, 17};
        vecs[3] = '{1'b1, 8'd10,  8'd5,   8'd0,   8'd0,   16'h0000, 1'b0, 1'b1, 88'h0, 0};
        vecs[4] = '{1'b0, 8'd0,   8'd240, 8'd0,   8'd0,   16'h0000, 1'b0, 1'b1, 88'h0, 0};
        vecs[5] = '{1'b1, 8'd0,   8'd0,   8'd0,   8'd135, 16'h0000, 1'b0, 1'b1, 88'h0, 0};
        vecs[6] = '{1'b0, 8'd0,   8'd0,   8'd4,   8'd3,   16'h0000, 1'b0, 1'b1, 88'h0, 0};
        vecs[7] = '{1'b0, 8'd239, 8'd239, 8'd134, 8'd134, 16'h0001, 1'b1, 1'b0, 88'h2A01170117_2B00BB00BB_2C, 13};
        vecs[8] = '{1'b1, 8'd0,   8'd1,   8'd0,   8'd0,   16'hF800, 1'b1, 1'b0, 88'h2A00280029_2B00350035_2C, 15};

        reset = 1'b1; init_done = 1'b1; out_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        set_req(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 16'h0);
        set_req(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 16'h0);
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", {15'd0, out_valid, out_last, busy, done, err, req0_ready, req1_ready, out_dc, out_data, active_id},
                            {15'd0, 7'b0000000, 1'b1, 8'h00, 1'b0});
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_job(vecs[i], $sformatf("v%0d", i));

        // Tie and alternation
        @(negedge clk);
        set_req(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 16'h1111);
        set_req(1'b1, 8'd1, 8'd1, 8'd1, 8'd1, 16'h2222);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("tie_r0", 32'({req0_ready, req1_ready}), 32'b10);
        @(negedge clk); req0_valid = 1'b0; #1;
        check("tie_id0", 32'(active_id), 32'd0);
        wait_done("tie_done0");
        @(negedge clk); #1;
        check("rr_r1", 32'({req0_ready, req1_ready}), 32'b01);
        @(negedge clk); req1_valid = 1'b0; #1;
        check("rr_id1", 32'(active_id), 32'd1);
        wait_done("rr_done1");
        @(negedge clk); req0_valid = 1'b1; req1_valid = 1'b1; #1;
        check("alt_r0", 32'({req0_ready, req1_ready}), 32'b10);
        @(negedge clk); req0_valid = 1'b0; #1;
        wait_done("alt_done0");
        @(negedge clk); #1;
        check("alt_r1", 32'({req0_ready, req1_ready}), 32'b01);
        @(negedge clk); req1_valid = 1'b0; #1;
        wait_done("alt_done1");

        // init_done gating
        @(negedge clk);
        init_done = 1'b0;
        set_req(1'b1, 8'd3, 8'd3, 8'd3, 8'd3, 16'h3333);
        req1_valid = 1'b1;
        nr = 0;
        for (int c = 0; c < 100; c++) begin
            #1; if (req1_ready) nr++;
            @(negedge clk);
        end
        check("gate_none", 32'(nr), 32'd0);
        init_done = 1'b1; #1;
        check("gate_rdy", 32'(req1_ready), 32'd1);
        @(negedge clk); req1_valid = 1'b0; #1;
        wait_done("gate_done");

        // Reset during PIXEL of a full-screen job
        @(negedge clk);
        set_req(1'b1, 8'd0, 8'd239, 8'd0, 8'd134, 16'h07E0);
        req1_valid = 1'b1; #1;
        check("fs_ready", 32'(req1_ready), 32'd1);
        @(negedge clk); req1_valid = 1'b0; #1;
        cnt = 0;
        for (int c = 0; c < 1000 && cnt < 211; c++) begin
            if (out_valid && out_ready) cnt++;
            if (cnt < 211) begin @(negedge clk); #1; end
        end
        @(negedge clk); #1;
        check("fs_pix100", {22'd0, out_valid, out_dc, out_data}, {22'd0, 1'b1, 1'b1, 8'h07});
        check("fs_id", 32'(active_id), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        set_req(1'b0, 8'd0, 8'd1, 8'd0, 8'd0, 16'hF800);
        req0_valid = 1'b1;
        @(negedge clk); #1;
        check("midrst_outs", {15'd0, out_valid, out_last, busy, done, err, req0_ready, req1_ready, out_dc, out_data, active_id},
                             {15'd0, 7'b0000000, 1'b1, 8'h00, 1'b0});
        req0_valid = 1'b0;
        reset = 1'b0;
        run_job(vecs[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
